// File: rtl/sipo8way.sv
// Serial-in/parallel-out deserializer with a valid/ready word handshake.
// Optional registered OR-reduction output out_any when SIPO8WAY_ANY_EN is defined.
module sipo8way #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_clr,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_valid,
`ifdef SIPO8WAY_ANY_EN
  output logic             out_any,
`endif
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             lastBit;
`ifdef SIPO8WAY_ANY_EN
  logic             any_q, any_d;
`endif

  // State register; rst overrides every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
      shift_q <= '0;
      word_q  <= '0;
`ifdef SIPO8WAY_ANY_EN
      any_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      word_q  <= word_d;
`ifdef SIPO8WAY_ANY_EN
      any_q   <= any_d;
`endif
    end
  end

  always_comb begin
    if (MSB_FIRST) shifted = {shift_q[WIDTH-2:0], in_bit};
    else           shifted = {in_bit, shift_q[WIDTH-1:1]};
  end

  assign lastBit = (count_q == CW'(WIDTH - 1));

  // Next-state logic; in FULL the shift register is already clear, so a
  // pass-through bit shifted in becomes the first bit of the next word.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shift_d = shift_q;
    word_d  = word_q;
`ifdef SIPO8WAY_ANY_EN
    any_d   = any_q;
`endif
    case (state_q)
      FILL: begin
        if (in_clr) begin
          count_d = '0;
          shift_d = '0;
        end else if (accept) begin
          if (lastBit) begin
            count_d = '0;
            shift_d = '0;
            word_d  = shifted;
            state_d = FULL;
`ifdef SIPO8WAY_ANY_EN
            any_d   = |shifted;
`endif
          end else begin
            count_d = count_q + CW'(1);
            shift_d = shifted;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = FILL;
          count_d = '0;
          shift_d = '0;
          if (!in_clr && accept) begin
            count_d = CW'(1);
            shift_d = shifted;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == FILL) ? 1'b1 : out_ready;
    out_valid = (state_q == FULL);
    accept    = in_valid && in_ready;
  end

  assign out_y = word_q;
`ifdef SIPO8WAY_ANY_EN
  assign out_any = any_q;
`endif

endmodule

// File: tb/tb_sipo8way.sv
// Directed bench for sipo8way: LSB-first and MSB-first instances share one
// input stream, so every word is checked in both bit orders.
module tb_sipo8way;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, in_clr, in_valid, in_bit, out_ready;
   logic       inReadyL, outValidL, inReadyM, outValidM;
   logic [7:0] outYL, outYM;
`ifdef SIPO8WAY_ANY_EN
   logic       outAnyL, outAnyM;
`endif

   int testsRun    = 0;
   int testsFailed = 0;

   sipo8way #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
      .clk(clk), .rst(rst), .in_clr(in_clr), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(inReadyL), .out_y(outYL), .out_valid(outValidL),
`ifdef SIPO8WAY_ANY_EN
      .out_any(outAnyL),
`endif
      .out_ready(out_ready)
   );

   sipo8way #(.WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
      .clk(clk), .rst(rst), .in_clr(in_clr), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(inReadyM), .out_y(outYM), .out_valid(outValidM),
`ifdef SIPO8WAY_ANY_EN
      .out_any(outAnyM),
`endif
      .out_ready(out_ready)
   );

   // Counts every comparison and reports each mismatch on one line.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Inputs change 1ns after a rising edge, outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic b, input logic clr, input logic ordy);
      in_valid  = v;
      in_bit    = b;
      in_clr    = clr;
      out_ready = ordy;
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7-i];
      return r;
   endfunction

   // Sends v[0] first; out_valid must stay low until the eighth bit lands.
   task automatic sendByte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, v[i], 1'b0, 1'b0);
         tick();
         checkOutput("fill_valid", {31'd0, outValidL}, {31'd0, (i == 7)});
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkWord(input string tag, input logic [7:0] lsbWord);
      checkOutput({tag, "_valid"}, {31'd0, outValidL}, 32'd1);
      checkOutput({tag, "_validM"}, {31'd0, outValidM}, 32'd1);
      checkOutput({tag, "_yLsb"}, {24'd0, outYL}, {24'd0, lsbWord});
      checkOutput({tag, "_yMsb"}, {24'd0, outYM}, {24'd0, rev8(lsbWord)});
`ifdef SIPO8WAY_ANY_EN
      checkOutput({tag, "_anyL"}, {31'd0, outAnyL}, {31'd0, (lsbWord != 8'h00)});
      checkOutput({tag, "_anyM"}, {31'd0, outAnyM}, {31'd0, (lsbWord != 8'h00)});
`endif
   endtask

   task automatic consume();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("consume_valid", {31'd0, outValidL}, 32'd0);
   endtask

   logic [7:0] words [3];

   initial begin
      words = '{8'h01, 8'hFF, 8'h80};
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst_valid", {31'd0, outValidL}, 32'd0);
      checkOutput("rst_y", {24'd0, outYL}, 32'd0);
      checkOutput("rst_ready", {31'd0, inReadyL}, 32'd1);
      rst = 1'b0;

      // LSB-first 1,0,1,0,... then hold the word while the consumer stalls.
      sendByte(8'h55);
      checkWord("w55", 8'h55);
      checkOutput("w55_inready", {31'd0, inReadyL}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("hold_valid", {31'd0, outValidL}, 32'd1);
         checkOutput("hold_y", {24'd0, outYL}, 32'h55);
      end
      consume();

      // Bits 0,0,0,0,1,1,1,1 give 0x0F in MSB-first order; then an all-zero word.
      sendByte(8'hF0);
      checkWord("wF0", 8'hF0);
      consume();
      sendByte(8'h00);
      checkWord("w00", 8'h00);
      consume();

      // Continuous stream with the consumer always ready.
      for (int k = 0; k < 24; k++) begin
         applyStimulus(1'b1, words[k/8][k%8], 1'b0, 1'b1);
         tick();
         checkOutput("stream_valid", {31'd0, outValidL}, {31'd0, ((k % 8) == 7)});
         if ((k % 8) == 7) begin
            checkOutput("stream_yLsb", {24'd0, outYL}, {24'd0, words[k/8]});
            checkOutput("stream_yMsb", {24'd0, outYM}, {24'd0, rev8(words[k/8])});
         end
      end
      consume();

      // Three bits, then a clear that also carries a bit; neither survives.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      checkOutput("clr_valid", {31'd0, outValidL}, 32'd0);
      sendByte(8'hA5);
      checkWord("wA5", 8'hA5);
      consume();

      // Reset in the middle of a word.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midrst_valid", {31'd0, outValidL}, 32'd0);
      checkOutput("midrst_yLsb", {24'd0, outYL}, 32'd0);
      checkOutput("midrst_yMsb", {24'd0, outYM}, 32'd0);
      checkOutput("midrst_ready", {31'd0, inReadyL}, 32'd1);
      sendByte(8'h3C);
      checkWord("w3C", 8'h3C);

      // Stalled FULL ignores offered bits.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, i[0], 1'b0, 1'b0);
         #1;
         checkOutput("full_inready", {31'd0, inReadyL}, 32'd0);
         tick();
         checkOutput("full_y", {24'd0, outYL}, 32'h3C);
         checkOutput("full_valid", {31'd0, outValidL}, 32'd1);
      end

      // Pass-through bit becomes the first bit of the next word.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("pass_valid", {31'd0, outValidL}, 32'd0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
         tick();
         checkOutput("pass_fill_valid", {31'd0, outValidL}, {31'd0, (i == 6)});
      end
      checkWord("w01", 8'h01);

      // Clear in FULL discards the pass-through bit and the word is consumed.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      checkOutput("fullclr_valid", {31'd0, outValidL}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
         tick();
         checkOutput("fullclr_fill_valid", {31'd0, outValidL}, {31'd0, (i == 7)});
      end
      checkWord("wclr00", 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
